// File: rtl/memory_handler_pkg.sv
// memory_handler_pkg: shared processor types, memory-handler FSM states and timeout default.
package memory_handler_pkg;
    typedef enum logic [2:0] {INST_R, INST_I, INST_S, INST_B, INST_U, INST_J} inst_type;
    typedef enum logic [1:0] {FOP_ADD, FOP_SUB, FOP_MUL, FOP_DIV} fop_t;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mh_state_t;
    localparam int MEM_TIMEOUT_DEFAULT = 255;
    function automatic logic [3:0] lane_sel(input logic is_byte, input logic [1:0] lane);
        return is_byte ? 4'b0001 << lane : 4'b1111;
    endfunction
endpackage

// File: rtl/memory_handler_if.sv
// memory_handler_if: simple strobe/busy memory bus between the handler and memory.
interface memory_handler_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_ren;
    logic        bus_wen;
    logic        bus_busy;
    modport master(output bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen, input bus_rdata, bus_busy);
    modport slave(input bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen, output bus_rdata, bus_busy);
endinterface

// File: rtl/load_extender.sv
// load_extender: selects the addressed byte lane and sign-extends it, or passes a full word.
module load_extender (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        is_byte,
    output logic [31:0] data
);
    logic [7:0] b;
    always_comb begin
        b = rdata[{lane, 3'b000} +: 8];
        data = is_byte ? {{24{b[7]}}, b} : rdata;
    end
endmodule

// File: rtl/memory_handler.sv
// memory_handler: load/store unit bridging pipeline requests to the memory bus with stall,
// alignment checking and a bus-busy timeout.
module memory_handler
    import memory_handler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   read_mem,
    input  logic                   write_mem,
    input  logic                   load_byte,
    input  logic                   store_byte,
    input  logic [31:0]            addr,
    input  logic [31:0]            store_data,
    output logic [31:0]            load_data,
    output logic                   mem_stall,
    output logic                   done,
    output logic                   err,
    memory_handler_if.master       bus
);
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    mh_state_t   state, state_nx;
    logic [CW-1:0] cnt;
    logic        is_write, is_byte, err_flag;
    logic [1:0]  lane;
    logic        req, req_byte, bad, timeout;
    logic [31:0] ext_data;

    load_extender u_ext (
        .rdata  (bus.bus_rdata),
        .lane   (lane),
        .is_byte(is_byte),
        .data   (ext_data)
    );

    always_comb begin
        req = read_mem | write_mem;
        req_byte = write_mem ? store_byte : load_byte;
        bad = (read_mem & write_mem) | (~req_byte & |addr[1:0]);
        timeout = bus.bus_busy & (cnt == CW'(TIMEOUT_CYCLES - 1));
        state_nx = state;
        mem_stall = 1'b0;
        done = 1'b0;
        err = 1'b0;
        bus.bus_ren = 1'b0;
        bus.bus_wen = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = req;
                state_nx = !req ? IDLE : bad ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_stall = 1'b1;
                bus.bus_ren = ~is_write;
                bus.bus_wen = is_write;
                state_nx = (!bus.bus_busy || timeout) ? DONE : ACCESS;
            end
            DONE: begin
                done = 1'b1;
                err = err_flag;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else state <= state_nx;
    end

    // err_flag tracks the outcome: set by a rejected request or by a busy (timed-out) exit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            load_data <= '0;
            bus.bus_addr <= '0;
            bus.bus_wdata <= '0;
            bus.bus_sel <= '0;
            is_write <= 1'b0;
            is_byte <= 1'b0;
            lane <= '0;
            err_flag <= 1'b0;
            cnt <= '0;
        end else begin
            if (state == IDLE && req) begin
                bus.bus_addr <= {addr[31:2], 2'b00};
                bus.bus_wdata <= req_byte ? {4{store_data[7:0]}} : store_data;
                bus.bus_sel <= lane_sel(req_byte, addr[1:0]);
                is_write <= write_mem;
                is_byte <= req_byte;
                lane <= addr[1:0];
                err_flag <= bad;
                cnt <= '0;
            end
            if (state == ACCESS) begin
                cnt <= cnt + CW'(bus.bus_busy);
                err_flag <= bus.bus_busy;
                if (!bus.bus_busy && !is_write) load_data <= ext_data;
            end
        end
    end
endmodule

// File: tb/tb_memory_handler.sv
// tb_memory_handler: randomized scoreboard bench for memory_handler against a behavioural model.
module tb_memory_handler;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read_mem = 1'b0, write_mem = 1'b0, load_byte = 1'b0, store_byte = 1'b0;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] load_data;
    logic        mem_stall, done, err;

    memory_handler_if bus();

    memory_handler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .read_mem  (read_mem),
        .write_mem (write_mem),
        .load_byte (load_byte),
        .store_byte(store_byte),
        .addr      (addr),
        .store_data(store_data),
        .load_data (load_data),
        .mem_stall (mem_stall),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          cyc;
    } done_t;
    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  sel;
        logic [31:0] wd;
    } bus_t;

    done_t       dq[$];
    bus_t        bq[$];
    done_t       de;
    bus_t        be;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] ref_ld = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (done) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    de = dq.pop_front();
                    check("done_err", 32'(err), 32'(de.err));
                    check("load_data", load_data, de.ld);
                    check("done_cycle", cyc, de.cyc);
                    check("stall_in_done", 32'(mem_stall), 0);
                end
            end else if (err) begin
                checks++;
                failures++;
                $display("FAIL err_without_done actual=1 expected=0 at cycle %0d", cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && (bus.bus_ren || bus.bus_wen) && !bus.bus_busy) begin
            if (bq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_unexpected actual=strobe expected=none at cycle %0d", cyc);
            end else begin
                be = bq.pop_front();
                check("bus_wen", 32'(bus.bus_wen), 32'(be.we));
                check("bus_ren", 32'(bus.bus_ren), 32'(!be.we));
                check("bus_addr", bus.bus_addr, be.a);
                check("bus_sel", 32'(bus.bus_sel), 32'(be.sel));
                if (be.we) check("bus_wdata", bus.bus_wdata, be.wd);
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic lb, input logic sb,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                          input int k);
        int n;
        logic byt, bad, to;
        logic [31:0] lane_v;
        done_t d;
        bus_t b;
        @(posedge clk); #1;
        read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb;
        addr = a; store_data = sd; bus.bus_rdata = rdat; bus.bus_busy = 1'b0;
        byt = wr ? sb : lb;
        bad = (rd && wr) || (!byt && (a % 4) != 0);
        to = !bad && k >= TO;
        if (!bad && !to) begin
            b.we = wr;
            b.a = a - (a % 4);
            b.sel = byt ? 4'(1 << (a % 4)) : 4'hF;
            b.wd = byt ? (sd & 32'hFF) * 32'h01010101 : sd;
            bq.push_back(b);
            if (rd) begin
                lane_v = (rdat >> (8 * (a % 4))) & 32'hFF;
                ref_ld = !byt ? rdat : (lane_v >= 128) ? lane_v - 32'd256 : lane_v;
            end
        end
        d.err = bad || to;
        d.ld = ref_ld;
        d.cyc = cyc + (bad ? 1 : to ? TO + 1 : k + 2);
        dq.push_back(d);
        n = 0;
        @(posedge clk); #1;
        while ((bus.bus_ren || bus.bus_wen) && n < 64) begin
            bus.bus_busy = (n < k);
            n++;
            @(posedge clk); #1;
        end
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL access_bound actual=%0d expected<64 cycles", n);
        end
        read_mem = 1'b0; write_mem = 1'b0; bus.bus_busy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic rd, wr, lb, sb;
        int op, k;
        bus.bus_busy = 1'b0;
        bus.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_data", load_data, 0);
        check("rst_bus_addr", bus.bus_addr, 0);
        check("rst_bus_wdata", bus.bus_wdata, 0);
        check("rst_bus_sel", 32'(bus.bus_sel), 0);
        check("rst_strobes", 32'({bus.bus_ren, bus.bus_wen}), 0);
        check("rst_done_err", 32'({done, err}), 0);
        check("rst_stall", 32'(mem_stall), 0);
        nrst = 1'b1;

        access(1, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        access(0, 1, 0, 1, 32'h103, 32'h000000A5, 32'h0, 0);
        access(1, 0, 1, 0, 32'h102, 32'h0, 32'h00800000, 0);
        access(1, 0, 0, 0, 32'h101, 32'h0, 32'h12345678, 0);
        access(1, 0, 0, 0, 32'h104, 32'h0, 32'hCAFEF00D, 6);
        access(1, 1, 0, 0, 32'h108, 32'h11223344, 32'h55667788, 0);
        access(0, 1, 0, 0, 32'h10C, 32'h89ABCDEF, 32'h0, 3);
        access(1, 0, 1, 0, 32'h201, 32'h0, 32'h00007F00, 2);

        @(posedge clk); #1;
        read_mem = 1'b1; load_byte = 1'b0; addr = 32'h200; bus.bus_busy = 1'b1;
        @(posedge clk); #1;
        check("ren_before_reset", 32'(bus.bus_ren), 1);
        #2;
        nrst = 1'b0;
        read_mem = 1'b0;
        #1;
        check("reset_ren", 32'({bus.bus_ren, bus.bus_wen}), 0);
        check("reset_stall", 32'(mem_stall), 0);
        check("reset_load_data", load_data, 0);
        ref_ld = '0;
        @(posedge clk); #1;
        check("reset_held_strobes", 32'({bus.bus_ren, bus.bus_wen, mem_stall}), 0);
        nrst = 1'b1;
        bus.bus_busy = 1'b0;
        access(1, 0, 0, 0, 32'h300, 32'h0, 32'h0BADF00D, 0);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom % 8);
            rd = (op < 4) || (op == 7);
            wr = (op >= 4);
            lb = 1'($urandom % 2);
            sb = 1'($urandom % 2);
            k = ($urandom % 5 == 0) ? TO + int'($urandom % 2) : int'($urandom % 3);
            access(rd, wr, lb, sb, $urandom, $urandom, $urandom, k);
        end

        repeat (3) @(posedge clk);
        #1;
        check("done_queue_empty", dq.size(), 0);
        check("bus_queue_empty", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_handler.md
MEMORY_HANDLER -- requirements
Module: memory_handler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of bus-busy cycles after which an access is aborted.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 read_mem, write_mem  input  1 each  load/store request from the control logic unit; level, held while mem_stall=1.
REQ-005 load_byte, store_byte  input  1 each  byte-width qualifiers for the load/store; 0 means word.
REQ-006 addr  input  32  effective address from the ALU.
REQ-007 store_data  input  32  rs2 value to store.
REQ-008 load_data  output  32  loaded value to the writeback mux.
REQ-009 mem_stall  output  1  freezes the pipeline while an access is outstanding.
REQ-010 done  output  1  one-cycle pulse when an access completes.
REQ-011 err  output  1  one-cycle pulse on misaligned, conflicting or timed-out access.
REQ-012 bus_addr  output  32  word-aligned bus address.
REQ-013 bus_wdata  output  32  bus write data.
REQ-014 bus_sel  output  4  byte-lane enables.
REQ-015 bus_ren, bus_wen  output  1 each  bus read/write strobes.
REQ-016 bus_rdata  input  32  bus read data, valid when bus_busy=0 during a strobe.
REQ-017 bus_busy  input  1  bus not ready.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE.
REQ-019 IDLE: mem_stall = read_mem|write_mem (combinational); on that edge, request captured (addr, data, sel, direction) and FSM enters ACCESS.
REQ-020 Conflicting request (read_mem=1 and write_mem=1) or word access with addr[1:0]!=0: no bus strobe, FSM enters DONE, err pulses in DONE.
REQ-021 ACCESS: bus_ren or bus_wen held high, mem_stall=1; bus_addr = {addr[31:2],2'b00}.
REQ-022 ACCESS exits to DONE on the first edge with bus_busy=0; read data captured on that edge.
REQ-023 Timeout counter (8 bits minimum) clears on entry to ACCESS and increments each cycle with bus_busy=1; reaching TIMEOUT_CYCLES gives exit to DONE with err, strobes dropped, load_data unchanged.
REQ-024 DONE: done=1, mem_stall=0, strobes low, requests ignored; next state IDLE unconditionally.
REQ-025 Word store: bus_sel=4'b1111, bus_wdata=store_data.
REQ-026 Byte store: bus_sel=4'b0001<<addr[1:0], bus_wdata = store_data[7:0] replicated in all 4 lanes.
REQ-027 Word load: load_data=bus_rdata.
REQ-028 Byte load: lane addr[1:0] selected and sign-extended to 32 bits.
REQ-029 load_data registered; held until the next successful load completes.
REQ-030 Back-to-back requests: minimum 3 cycles per access (IDLE, ACCESS, DONE) with zero-wait bus.

Reset
REQ-031 nrst low forces IDLE asynchronously; load_data, bus_addr, bus_wdata = 0; bus_sel = 0; strobes, done, err = 0; counter = 0.
REQ-032 Reset mid-ACCESS drops strobes immediately; the aborted access is not retried.

Structure
REQ-033 State enum and TIMEOUT default placed in the shared processor package beside inst_type/fop_t.
REQ-034 One sub-module, load_extender (lane select plus sign extension), combinational.

Verification
REQ-035 Word load at 0x100, bus_busy=0, bus_rdata=0xDEADBEEF -> done in cycle 3, load_data=0xDEADBEEF, err=0.
REQ-036 Byte store at 0x103, store_data=0x000000A5 -> bus_sel=4'b1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
REQ-037 Byte load at 0x102, bus_rdata=0x00800000 -> load_data=0xFFFFFF80.
REQ-038 Word load at 0x101 -> no strobe, err and done pulse together, mem_stall low after DONE.
REQ-039 bus_busy held high with TIMEOUT_CYCLES=4 -> strobes drop after 4 busy cycles, err pulse, load_data unchanged.
REQ-040 nrst asserted during ACCESS with bus_busy=1 -> strobes and mem_stall 0 immediately, FSM in IDLE.
